// File: rtl/tweet_ram_arbiter_if.sv
// Bus bundle between the tweetboard requesters, the tweet RAM and the
// tweet_ram_arbiter.
//   clr_*  : clear-sweep start/status
//   wr_*   : serial receive writer (req/addr/data in, gnt/err out)
//   rd_*   : playback reader (req/addr in, gnt/valid/data out)
//   ram_*  : single RAM port (write/addr/data_in out, data_out in)
// Modport slave is the arbiter's view; master is everything around it.
interface tweet_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              wr_err;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    modport slave (
        input  clr_start, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_out,
        output clr_busy, clr_done, wr_gnt, wr_err, rd_gnt, rd_valid, rd_data,
               ram_write, ram_addr, ram_data_in
    );

    modport master (
        output clr_start, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_out,
        input  clr_busy, clr_done, wr_gnt, wr_err, rd_gnt, rd_valid, rd_data,
               ram_write, ram_addr, ram_data_in
    );
endinterface

// File: rtl/tweet_ram_arbiter.sv
// tweet_ram_arbiter: owns the single port of the tweet RAM and shares it
// between the internal clear sweeper, the receive writer and the playback
// reader. At most one RAM operation per cycle; all RAM-side outputs and
// grants are registered, so a request seen in cycle N is served in N+1.
// Ports:
//   sysclk : clock
//   reset  : synchronous, active-high
//   bus    : tweet_ram_arbiter_if.slave (clr_*, wr_*, rd_*, ram_*)
module tweet_ram_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int LAST_ADDR = 255,
    parameter int WR_LIMIT  = 160
) (
    input  logic               sysclk,
    input  logic               reset,
    tweet_ram_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST   = LAST_ADDR[ADDR_W-1:0];
    // One extra bit so a limit equal to the full address space is expressible.
    localparam logic [ADDR_W:0]   WR_LIM = WR_LIMIT[ADDR_W:0];

    typedef enum logic [0:0] {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_rd_q, ptr_rd_d;   // 1: reader wins the next tie
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wg_q, wg_d;
    logic              we_q, we_d;
    logic              rg_q, rg_d;
    logic              rv_q, rv_d;
    logic              ramw_q, ramw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              pick_wr;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wg_q     <= 1'b0;
            we_q     <= 1'b0;
            rg_q     <= 1'b0;
            rv_q     <= 1'b0;
            ramw_q   <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_rd_q <= ptr_rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wg_q     <= wg_d;
            we_q     <= we_d;
            rg_q     <= rg_d;
            rv_q     <= rv_d;
            ramw_q   <= ramw_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_rd_d = ptr_rd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wg_d     = 1'b0;
        we_d     = 1'b0;
        rg_d     = 1'b0;
        // The read return depends only on the grant, so it survives a
        // clr_start arriving while the read is on the RAM pins.
        rv_d     = rg_q;
        ramw_d   = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        pick_wr  = bus.wr_req && (!bus.rd_req || !ptr_rd_q);

        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (pick_wr) begin
                    wg_d     = 1'b1;
                    ptr_rd_d = 1'b1;
                    if ({1'b0, bus.wr_addr} >= WR_LIM) begin
                        // Rejected: grant still pulses so the writer moves on.
                        we_d = 1'b1;
                    end else begin
                        ramw_d = 1'b1;
                        addr_d = bus.wr_addr;
                        din_d  = bus.wr_data;
                    end
                end else if (bus.rd_req) begin
                    rg_d     = 1'b1;
                    ptr_rd_d = 1'b0;
                    addr_d   = bus.rd_addr;
                end
            end
            SWEEP: begin
                ramw_d = 1'b1;
                addr_d = cnt_q;
                din_d  = '0;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.clr_busy    = busy_q;
    assign bus.clr_done    = done_q;
    assign bus.wr_gnt      = wg_q;
    assign bus.wr_err      = we_q;
    assign bus.rd_gnt      = rg_q;
    assign bus.rd_valid    = rv_q;
    // RAM output is stable for the whole valid cycle; pass it through and
    // hold it at zero otherwise.
    assign bus.rd_data     = rv_q ? bus.ram_data_out : '0;
    assign bus.ram_write   = ramw_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_data_in = din_q;

endmodule
